// File: rtl/parity_pkg.sv
// ----------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the parity-checked serial receiver:
//   - state_t               : receiver FSM states
//   - DEFAULT_CLKS_PER_BIT  : default oversampling factor (clocks per bit)
//   - DEFAULT_DATA_W        : default number of data bits per frame
//   - parityError()         : combines data XOR, received parity bit and the
//                             odd/even selector into a single error flag
// ----------------------------------------------------------------------------
package parity_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 4;
    localparam int DEFAULT_DATA_W       = 8;

    // Even parity: data XOR parity must be 0. Odd parity: must be 1.
    function automatic logic parityError(input logic dataXor,
                                         input logic parityBit,
                                         input logic oddSel);
        return dataXor ^ parityBit ^ oddSel;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// ----------------------------------------------------------------------------
// bit_timer
// Free-running bit-period counter with a mid-bit sample strobe.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset (counter cleared)
//   restart_i  : forces the counter back to 0 on the next edge
//   half_i     : 1 = strobe at count CLKS_PER_BIT/2 (start-bit midpoint)
//                0 = strobe at count CLKS_PER_BIT-1 (one full bit later)
//   sample_o   : combinational sample strobe for the current cycle
// ----------------------------------------------------------------------------
module bit_timer
    import parity_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    input  logic half_i,
    output logic sample_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The counter wraps at the end of every bit period, so after a restart
    // at one sample point the next full-bit strobe lands exactly one bit
    // period later, i.e. again at a bit midpoint.
    always_comb begin
        count_d = count_q + 1'b1;
        if (restart_i || (count_q == LAST_CNT)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign sample_o = half_i ? (count_q == HALF_CNT) : (count_q == LAST_CNT);

endmodule

// File: rtl/parity_rx.sv
// ----------------------------------------------------------------------------
// parity_rx
// Serial receiver for frames of: start(0), DATA_W data bits LSB first,
// one parity bit, one stop bit(1). Reports the data word with parity and
// framing error flags, pulsing out_valid for one cycle per frame.
// Ports:
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   in_serial      : serial line, idle high, asynchronous to clk
//   out_data       : last received data word (held until next frame)
//   out_valid      : one-cycle pulse when a frame completes
//   out_parity_err : parity mismatch of the last frame
//   out_frame_err  : stop bit of the last frame was sampled low
// ----------------------------------------------------------------------------
module parity_rx
    import parity_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_serial,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_parity_err,
    output logic              out_frame_err
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic ODD_SEL = (PARITY_ODD != 0);

    logic sync1_q;
    logic sync2_q;
    logic rx;

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
    logic [DATA_W-1:0] shift_q,      shift_d;
    logic              parity_bit_q, parity_bit_d;
    logic [DATA_W-1:0] data_q,       data_d;
    logic              valid_q,      valid_d;
    logic              perr_q,       perr_d;
    logic              ferr_q,       ferr_d;

    logic timer_restart;
    logic timer_half;
    logic sample;
    logic take_data;
    logic take_parity;
    logic take_stop;

    // Two-flop synchronizer; flops reset to the idle (high) line level so
    // reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= in_serial;
            sync2_q <= sync1_q;
        end
    end

    assign rx = sync2_q;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart_i(timer_restart),
        .half_i   (timer_half),
        .sample_o (sample)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!rx) state_d = START;
            end
            START: begin
                if (sample) state_d = rx ? IDLE : DATA;
            end
            DATA: begin
                if (sample && (bit_cnt_q == LAST_BIT)) state_d = PARITY;
            end
            PARITY: begin
                if (sample) state_d = STOP;
            end
            STOP: begin
                if (sample) state_d = rx ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (rx) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs. In IDLE the timer is held at 0 while the line is high,
    // so it is already counting from the first low cycle and the start-bit
    // strobe falls at the true midpoint of the start bit.
    always_comb begin
        timer_restart = 1'b0;
        timer_half    = 1'b0;
        take_data     = 1'b0;
        take_parity   = 1'b0;
        take_stop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_restart = rx;
                timer_half    = 1'b1;
            end
            START: begin
                timer_half    = 1'b1;
                timer_restart = sample;
            end
            DATA:      take_data     = sample;
            PARITY:    take_parity   = sample;
            STOP:      take_stop     = sample;
            WAIT_IDLE: timer_restart = 1'b1;
            default:   timer_restart = 1'b1;
        endcase
    end

    // Datapath next values: LSB-first shift in, parity capture, and the
    // result registers that update only at the stop-bit sample.
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_bit_d = parity_bit_q;
        data_d       = data_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        valid_d      = 1'b0;
        if (state_q == START) begin
            bit_cnt_d = '0;
        end
        if (take_data) begin
            shift_d   = (shift_q >> 1) | (DATA_W'(rx) << (DATA_W - 1));
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (take_parity) begin
            parity_bit_d = rx;
        end
        if (take_stop) begin
            data_d  = shift_q;
            perr_d  = parityError(^shift_q, parity_bit_q, ODD_SEL);
            ferr_d  = ~rx;
            valid_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_bit_q <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_bit_q <= parity_bit_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
        end
    end

    assign out_data       = data_q;
    assign out_valid      = valid_q;
    assign out_parity_err = perr_q;
    assign out_frame_err  = ferr_q;

endmodule

// File: tb/tb_parity_rx.sv
// ----------------------------------------------------------------------------
// tb_parity_rx
// Drives one serial line into two receivers (even and odd parity) and
// scores every completed frame against expectations queued when the frame
// is sent. Table vectors cover the basic parity/stop cases; hand-written
// sequences cover line break, start glitch, mid-frame reset and latency.
// ----------------------------------------------------------------------------
module tb_parity_rx;
    import parity_pkg::*;

    localparam int C = 4;
    localparam int W = 8;
    // Line drop to out_valid, counted in clock edges, including the two
    // synchronizer stages.
    localparam int LATENCY = (W + 2) * C + C / 2 + 1 + 2;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       parityBit;
        logic       stopBit;
        logic       expPerrEven;
        logic       expPerrOdd;
        logic       expFerr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line = 1'b1;
    logic [7:0] dataE, dataO;
    logic       validE, validO, perrE, perrO, ferrE, ferrO;

    exp_t qEven[$];
    exp_t qOdd[$];
    exp_t popE, popO;
    vec_t vecs[8];

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;
    int lastValidCycle = -1;
    int frameStartCycle = 0;
    int validCount = 0;
    int snap;

    parity_rx #(.CLKS_PER_BIT(C), .DATA_W(W), .PARITY_ODD(0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_serial     (line),
        .out_data      (dataE),
        .out_valid     (validE),
        .out_parity_err(perrE),
        .out_frame_err (ferrE)
    );

    parity_rx #(.CLKS_PER_BIT(C), .DATA_W(W), .PARITY_ODD(1)) dutOdd (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_serial     (line),
        .out_data      (dataO),
        .out_valid     (validO),
        .out_parity_err(perrO),
        .out_frame_err (ferrO)
    );

    // Free-running clock and an edge counter used for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard: every out_valid pulse pops one expectation per receiver.
    always @(negedge clk) begin
        if (validE === 1'b1) begin
            validCount++;
            lastValidCycle = cycleCnt;
            if (qEven.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL even_unexpected_valid: got pulse, expected none (data %0h)", dataE);
            end else begin
                popE = qEven.pop_front();
                checkOutput("even_data", 32'(dataE), 32'(popE.data));
                checkOutput("even_parity_err", 32'(perrE), 32'(popE.perr));
                checkOutput("even_frame_err", 32'(ferrE), 32'(popE.ferr));
            end
        end
        if (validO === 1'b1) begin
            if (qOdd.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL odd_unexpected_valid: got pulse, expected none (data %0h)", dataO);
            end else begin
                popO = qOdd.pop_front();
                checkOutput("odd_data", 32'(dataO), 32'(popO.data));
                checkOutput("odd_parity_err", 32'(perrO), 32'(popO.perr));
                checkOutput("odd_frame_err", 32'(ferrO), 32'(popO.ferr));
            end
        end
    end

    // Every bit task is entered and left on a falling clock edge.
    task automatic driveBit(input logic b);
        line = b;
        repeat (C) @(negedge clk);
    endtask

    task automatic idleBits(input int n);
        line = 1'b1;
        repeat (n * C) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic p, input logic s);
        frameStartCycle = cycleCnt;
        driveBit(1'b0);
        for (int i = 0; i < W; i++) driveBit(data[i]);
        driveBit(p);
        driveBit(s);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic p, input logic s,
                                 input logic expPerrEven, input logic expPerrOdd,
                                 input logic expFerr);
        qEven.push_back('{data, expPerrEven, expFerr});
        qOdd.push_back('{data, expPerrOdd, expFerr});
        sendFrame(data, p, s);
    endtask

    task automatic waitDrain(input int limit);
        int n = 0;
        while ((qEven.size() != 0 || qOdd.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (qEven.size() != 0 || qOdd.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d/%0d pending, expected 0",
                     qEven.size(), qOdd.size());
            qEven.delete();
            qOdd.delete();
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // data, parity bit, stop bit, expected perr even/odd, expected ferr
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset state.
        rst_n = 1'b0;
        line  = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_data", 32'(dataE), 32'h0);
        checkOutput("reset_valid", 32'(validE), 32'h0);
        checkOutput("reset_parity_err", 32'(perrE), 32'h0);
        checkOutput("reset_frame_err", 32'(ferrE), 32'h0);
        checkOutput("reset_state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        idleBits(2);

        // Table-driven frames.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].data, vecs[i].parityBit, vecs[i].stopBit,
                          vecs[i].expPerrEven, vecs[i].expPerrOdd, vecs[i].expFerr);
            idleBits(2);
            waitDrain(100);
            if (i == 0) begin
                checkOutput("latency", 32'(lastValidCycle - frameStartCycle), 32'(LATENCY));
            end
        end

        // Line break: stop bit low then line held low; receiver parks in
        // WAIT_IDLE until the line returns high.
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        line = 1'b0;
        repeat (20) @(negedge clk);
        waitDrain(10);
        checkOutput("break_state_even", 32'(dut.state_q), 32'(WAIT_IDLE));
        checkOutput("break_state_odd", 32'(dutOdd.state_q), 32'(WAIT_IDLE));
        idleBits(2);
        checkOutput("break_release_state", 32'(dut.state_q), 32'(IDLE));
        applyStimulus(8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idleBits(2);
        waitDrain(100);

        // Start glitch: one clock low is rejected at the start-bit midpoint.
        snap = validCount;
        line = 1'b0;
        @(negedge clk);
        idleBits(4);
        checkOutput("glitch_no_valid", 32'(validCount - snap), 32'h0);
        checkOutput("glitch_state", 32'(dut.state_q), 32'(IDLE));

        // Reset during data bit 3 aborts the frame; outputs return to 0.
        snap = validCount;
        driveBit(1'b0);
        driveBit(1'b1);
        driveBit(1'b0);
        driveBit(1'b1);
        line = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort_data", 32'(dataE), 32'h0);
        checkOutput("abort_valid", 32'(validE), 32'h0);
        checkOutput("abort_parity_err", 32'(perrO), 32'h0);
        checkOutput("abort_frame_err", 32'(ferrE), 32'h0);
        line = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idleBits(4);
        checkOutput("abort_no_valid", 32'(validCount - snap), 32'h0);
        applyStimulus(8'hF0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idleBits(2);
        waitDrain(100);

        checkOutput("final_even_queue", 32'(qEven.size()), 32'h0);
        checkOutput("final_odd_queue", 32'(qOdd.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
